// File: rtl/calc_arith_sequencer_if.sv
// Handshake/operand bundle between the key-entry FSM (master) and the
// arithmetic sequencer (slave).
//   iSTART/iCLR   : request and synchronous abort
//   iOP/iA/iB     : opcode and unsigned operands, captured on an accepted start
//   oBUSY/oDONE   : in-progress flag and single-cycle completion pulse
//   oRESULT/oREMAIN/oOVF/oERR : results, held until the next completion
interface calc_arith_sequencer_if #(
  parameter int WIDTH = 24
);
  logic             iSTART;
  logic             iCLR;
  logic [2:0]       iOP;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBUSY;
  logic             oDONE;
  logic [WIDTH-1:0] oRESULT;
  logic [WIDTH-1:0] oREMAIN;
  logic             oOVF;
  logic             oERR;

  modport slave (
    input  iSTART, iCLR, iOP, iA, iB,
    output oBUSY, oDONE, oRESULT, oREMAIN, oOVF, oERR
  );

  modport master (
    output iSTART, iCLR, iOP, iA, iB,
    input  oBUSY, oDONE, oRESULT, oREMAIN, oOVF, oERR
  );
endinterface

// File: rtl/calc_arith_sequencer.sv
// Multi-cycle arithmetic engine for the keypad calculator datapath.
// Add/sub finish in one execute cycle; mul/div iterate WIDTH times over a
// single shared WIDTH-bit adder (shift-add multiply, restoring divide).
// Ports:
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   bus (slave)  : start/clear/opcode/operands in; busy/done/results out
module calc_arith_sequencer #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  calc_arith_sequencer_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  // Counter reaches WIDTH after the last iteration; that extra cycle
  // publishes the result so the iteration loop never touches the outputs.
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state, state_nx, start_tgt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q, remain_q;
  logic               ovf_q, err_q;

  logic               busy, accept, iter_end;
  logic [WIDTH-1:0]   add_x, add_y;
  logic               add_ci;
  logic [WIDTH:0]     add_s;
  logic [WIDTH-1:0]   rem_sh;
  logic               div_keep;

  assign busy     = (state == S_EXEC) || (state == S_MUL) || (state == S_DIV);
  assign accept   = bus.iSTART && !busy && !bus.iCLR;
  assign iter_end = (cnt_q == CNT_END);

  assign bus.oBUSY   = busy;
  assign bus.oDONE   = (state == S_DONE);
  assign bus.oRESULT = result_q;
  assign bus.oREMAIN = remain_q;
  assign bus.oOVF    = ovf_q;
  assign bus.oERR    = err_q;

  // Remainder shifted left with the next dividend bit brought in.
  assign rem_sh = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};

  always_comb begin
    start_tgt = S_EXEC;
    if (bus.iOP == OP_MUL)                       start_tgt = S_MUL;
    else if (bus.iOP == OP_DIV && bus.iB != '0)  start_tgt = S_DIV;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.iCLR) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE:       if (bus.iSTART) state_nx = start_tgt;
        S_DONE:       state_nx = bus.iSTART ? start_tgt : S_IDLE;
        S_EXEC:       state_nx = S_DONE;
        S_MUL, S_DIV: if (iter_end) state_nx = S_DONE;
        default:      state_nx = S_IDLE;
      endcase
    end
  end

  // Shared adder: add/sub in EXEC, partial-product add in MUL,
  // trial subtract (x + ~B + 1) in DIV.
  always_comb begin
    add_x  = a_q;
    add_y  = b_q;
    add_ci = 1'b0;
    case (state)
      S_EXEC: if (op_q == OP_SUB) begin
        add_y  = ~b_q;
        add_ci = 1'b1;
      end
      S_MUL: begin
        add_x = acc_q[2*WIDTH-1:WIDTH];
        add_y = acc_q[0] ? a_q : '0;
      end
      S_DIV: begin
        add_x  = rem_sh;
        add_y  = ~b_q;
        add_ci = 1'b1;
      end
      default: ;
    endcase
    add_s = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
  end

  // The shifted remainder is WIDTH+1 bits wide; if its top bit (the old
  // remainder MSB) is set it already exceeds B, so the trial subtract
  // succeeds regardless of the low-part carry.
  assign div_keep = acc_q[2*WIDTH-1] | add_s[WIDTH];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      remain_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.iA;
      b_q   <= bus.iB;
      op_q  <= bus.iOP;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      acc_q <= (bus.iOP == OP_DIV) ? {{WIDTH{1'b0}}, bus.iA} : {{WIDTH{1'b0}}, bus.iB};
    end else if (!bus.iCLR) begin
      case (state)
        S_EXEC: begin
          case (op_q)
            OP_ADD: begin
              result_q <= add_s[WIDTH-1:0];
              remain_q <= '0;
              ovf_q    <= add_s[WIDTH];
            end
            OP_SUB: begin
              result_q <= add_s[WIDTH-1:0];
              remain_q <= '0;
              ovf_q    <= ~add_s[WIDTH];
            end
            OP_DIV: begin  // only reaches EXEC when B was zero
              result_q <= '1;
              remain_q <= a_q;
              err_q    <= 1'b1;
            end
            default: begin
              result_q <= '0;
              remain_q <= '0;
              err_q    <= 1'b1;
            end
          endcase
        end
        S_MUL: begin
          if (!iter_end) begin
            acc_q <= {add_s, acc_q[WIDTH-1:1]};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= acc_q[WIDTH-1:0];
            remain_q <= '0;
            ovf_q    <= |acc_q[2*WIDTH-1:WIDTH];
          end
        end
        S_DIV: begin
          if (!iter_end) begin
            acc_q <= {(div_keep ? add_s[WIDTH-1:0] : rem_sh), acc_q[WIDTH-2:0], div_keep};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= acc_q[WIDTH-1:0];
            remain_q <= acc_q[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arith_sequencer.sv
module tb_calc_arith_sequencer;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  calc_arith_sequencer_if #(.WIDTH(W)) bus ();
  calc_arith_sequencer #(.WIDTH(W), .CNT_W(5)) dut (.iCLK(clk), .iRST_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain arithmetic from the opcode rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                output logic [W-1:0] r, output logic [W-1:0] rm,
                                output logic o, output logic e, output int lat);
    longint p;
    r = '0; rm = '0; o = 1'b0; e = 1'b0; lat = 2;
    case (op)
      3'd0: begin p = longint'(a) + longint'(b); r = p[W-1:0]; o = p > 64'hFFFFFF; end
      3'd1: begin p = longint'(a) - longint'(b); r = p[W-1:0]; o = a < b; end
      3'd2: begin p = longint'(a) * longint'(b); r = p[W-1:0]; o = (p >> W) != 0; lat = W + 2; end
      3'd3: if (b == 0) begin r = '1; rm = a; e = 1'b1; end
            else begin r = a / b; rm = a % b; lat = W + 2; end
      default: e = 1'b1;
    endcase
  endfunction

  // Drives a start; returns at #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk);
    bus.iA = a; bus.iB = b; bus.iOP = op; bus.iSTART = 1'b1;
    @(posedge clk); #1;
    bus.iSTART = 1'b0;
  endtask

  // Counts edges (accepting edge = 1) until oDONE is seen; bounded.
  task automatic wait_done(output int lat, output int busyc);
    lat = 1; busyc = 0;
    while (!bus.oDONE && lat < 60) begin
      if (bus.oBUSY) busyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    bus.iSTART = 0; bus.iCLR = 0; bus.iOP = 0; bus.iA = 0; bus.iB = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.oBUSY, bus.oDONE, bus.oOVF, bus.oERR, bus.oRESULT, bus.oREMAIN} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b err=%b res=%h rem=%h, want all 0",
               bus.oBUSY, bus.oDONE, bus.oOVF, bus.oERR, bus.oRESULT, bus.oREMAIN);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic run_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
    logic [W-1:0] er, erm; logic eo, ee; int el, lat, bc;
    model(a, b, op, er, erm, eo, ee, el);
    start_op(a, b, op);
    wait_done(lat, bc);
    total++;
    if (lat !== el || bc !== el - 1) begin
      bad++;
      $display("FAIL %s_latency: got lat=%0d busy=%0d, want lat=%0d busy=%0d", nm, lat, bc, el, el - 1);
    end
    total++;
    if (bus.oRESULT !== er || bus.oREMAIN !== erm) begin
      bad++;
      $display("FAIL %s_result: a=%h b=%h op=%0d got res=%h rem=%h, want res=%h rem=%h",
               nm, a, b, op, bus.oRESULT, bus.oREMAIN, er, erm);
    end
    total++;
    if (bus.oOVF !== eo || bus.oERR !== ee) begin
      bad++;
      $display("FAIL %s_flags: a=%h b=%h op=%0d got ovf=%b err=%b, want ovf=%b err=%b",
               nm, a, b, op, bus.oOVF, bus.oERR, eo, ee);
    end
    @(posedge clk); #1;
    total++;
    if (bus.oDONE !== 1'b0 || bus.oRESULT !== er) begin
      bad++;
      $display("FAIL %s_hold: got done=%b res=%h, want done=0 res=%h", nm, bus.oDONE, bus.oRESULT, er);
    end
  endtask

  task automatic test_directed;
    run_check("add",    24'd123,     24'd456,  3'd0);
    run_check("sub",    24'd5,       24'd7,    3'd1);
    run_check("addovf", 24'hFFFFFF,  24'd1,    3'd0);
    run_check("mul",    24'd1000,    24'd1000, 3'd2);
    run_check("mulovf", 24'd4096,    24'd4096, 3'd2);
    run_check("div",    24'd100,     24'd7,    3'd3);
    run_check("div0",   24'd9,       24'd0,    3'd3);
    run_check("illeg",  24'd77,      24'd3,    3'd5);
    run_check("divbig", 24'hFFFFFF,  24'h800001, 3'd3);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b; logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom) >> $urandom_range(0, 20);
      b  = W'($urandom) >> $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) b = '0;
      op = 3'($urandom_range(0, 7));
      if (op[2] && $urandom_range(0, 2) != 0) op[2] = 1'b0;
      run_check("rand", a, b, op);
    end
  endtask

  task automatic test_clear;
    int seen;
    run_check("preclr", 24'd123, 24'd456, 3'd0);
    start_op(24'd1000, 24'd1000, 3'd2);       // edge 1
    repeat (8) @(posedge clk);                 // through edge 9
    #1; bus.iCLR = 1;
    @(posedge clk); #1;                        // edge 10
    bus.iCLR = 0;
    total++;
    if (bus.oBUSY !== 1'b0) begin
      bad++; $display("FAIL clr_busy: got busy=%b, want 0", bus.oBUSY);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.oDONE) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0 || bus.oRESULT !== 24'd579 || bus.oREMAIN !== 24'd0) begin
      bad++;
      $display("FAIL clr_hold: got dones=%0d res=%h rem=%h, want dones=0 res=%h rem=0",
               seen, bus.oRESULT, bus.oREMAIN, 24'd579);
    end
    // start and clear together: start is dropped
    @(negedge clk);
    bus.iA = 24'd3; bus.iB = 24'd4; bus.iOP = 3'd0; bus.iSTART = 1; bus.iCLR = 1;
    @(posedge clk); #1;
    bus.iSTART = 0; bus.iCLR = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.oDONE || bus.oBUSY) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0 || bus.oRESULT !== 24'd579) begin
      bad++;
      $display("FAIL clr_start: got active_cycles=%0d res=%h, want 0 and res=%h", seen, bus.oRESULT, 24'd579);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, bc, seen;
    start_op(24'd1000, 24'd1000, 3'd2);       // edge 1
    repeat (4) @(posedge clk);                 // edge 5
    #1;
    bus.iSTART = 1; bus.iOP = 3'd0; bus.iA = 24'd1; bus.iB = 24'd2;
    @(posedge clk); #1;                        // edge 6
    bus.iSTART = 0;
    wait_done(lat, bc);
    lat += 5;
    total++;
    if (lat != 26 || bus.oRESULT !== 24'd1000000) begin
      bad++;
      $display("FAIL busy_ignore: got lat=%0d res=%h, want lat=26 res=%h", lat, bus.oRESULT, 24'd1000000);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.oDONE || bus.oBUSY) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL busy_noqueue: got active_cycles=%0d, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] er, erm; logic eo, ee; int el, lat, bc;
    start_op(24'd100, 24'd7, 3'd3);
    wait_done(lat, bc);
    total++;
    if (lat != 26 || bus.oRESULT !== 24'd14 || bus.oREMAIN !== 24'd2) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d res=%h rem=%h, want lat=26 res=e rem=2", lat, bus.oRESULT, bus.oREMAIN);
    end
    for (int k = 0; k < 3; k++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = (k == 0) ? 3'd0 : (k == 1) ? 3'd2 : 3'd1;
      a = W'($urandom); b = W'($urandom) >> 8;
      model(a, b, op, er, erm, eo, ee, el);
      bus.iA = a; bus.iB = b; bus.iOP = op; bus.iSTART = 1;  // during the oDONE cycle
      @(posedge clk); #1;
      bus.iSTART = 0;
      wait_done(lat, bc);
      total++;
      if (lat != el || bus.oRESULT !== er || bus.oOVF !== eo) begin
        bad++;
        $display("FAIL b2b_next: op=%0d got lat=%0d res=%h ovf=%b, want lat=%0d res=%h ovf=%b",
                 op, lat, bus.oRESULT, bus.oOVF, el, er, eo);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    start_op(24'd1234, 24'd567, 3'd2);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if (bus.oBUSY !== 1'b0 || bus.oRESULT !== '0 || bus.oDONE !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b res=%h, want 0 0 0", bus.oBUSY, bus.oDONE, bus.oRESULT);
    end
    @(negedge clk); rst_n = 1;
    run_check("postrst", 24'd20, 24'd6, 3'd3);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_clear;
    test_busy_ignore;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
